// File: rtl/shift_add_mult_ctrl_pkg.sv
// rtl/shift_add_mult_ctrl_pkg.sv - shared state encoding for the shift-add multiplier
package shift_add_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_lshift.sv
// rtl/shift_add_mult_ctrl_lshift.sv - combinational left shifter driven by a one-hot code
module onehot_lshift #(
    parameter int W = 16
) (
    input  logic [W-1:0] code,
    input  logic [W-1:0] d,
    output logic [W-1:0] out
);

    // code[W-1] selects shift 0, code[0] selects shift W-1; an all-zero code yields 0
    always_comb begin
        out = '0;
        for (int s = 0; s < W; s++) begin
            if (code[W-1-s]) begin
                out = out | (d << s);
            end
        end
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - sequential unsigned shift-and-add multiplier controller
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   sh_code
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc, acc_next, partial;
    logic [KW-1:0]      k;
    logic               last_bit;

    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign sh_code = busy ? ({1'b1, {(WIDTH-1){1'b0}}} >> k) : '0;

    // Only the small-shift half of the wide shifter's code is ever used,
    // so the large-shift half is tied low.
    onehot_lshift #(.W(2*WIDTH)) u_shift (
        .code ({sh_code, {WIDTH{1'b0}}}),
        .d    ({{WIDTH{1'b0}}, a_r}),
        .out  (partial)
    );

    assign acc_next = b_r[k] ? (acc + partial) : acc;
    assign last_bit = (k == K_LAST) || (EARLY_EXIT && (((b_r >> k) >> 1) == '0));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            k       <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        k   <= '0;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    k   <= k + KW'(1);
                    // Load the result on the way into DONE so it is valid alongside the done pulse
                    if (last_bit) begin
                        product <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
